dsp_macc_pipe: RTL
==================

DSP_MACC_PIPE -- requirements
Module: dsp_macc_pipe

Interface
REQ-001 SHALL provide parameter A_W, default 25, width of unsigned operands a and d (2..26).
REQ-002 SHALL provide parameter B_W, default 17, width of unsigned operand b (2..18).
REQ-003 SHALL provide parameter P_W, default 48, width of c and out (A_W+1+B_W <= P_W <= 48).
REQ-004 SHALL provide parameter STAGES, default 3, pipeline depth (1..4); values outside the range SHALL fail elaboration.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-007 ce  input  1  clock enable; 0 freezes every register in the block.
REQ-008 in_valid  input  1  operand set valid this cycle (sampled only when ce=1).
REQ-009 a, d  input  A_W each  pre-adder operands.
REQ-010 b  input  B_W  multiplier operand.
REQ-011 c  input  P_W  post-adder operand.
REQ-012 mode  input  4  [0] pre_en, [1] pre_sub, [2] post_sub, [3] acc; sampled with in_valid.
REQ-013 acc_clr  input  1  with acc=1, treat accumulator as zero for this operand set.
REQ-014 out_valid  output  1  out carries a new result.
REQ-015 out  output  P_W  registered result.

Function
REQ-016 Pre-adder: pre = pre_en ? (pre_sub ? a-d : a+d) : a, A_W+1 bits, unsigned, modulo 2^(A_W+1).
REQ-017 Product: m = pre*b, A_W+1+B_W bits, zero-extended to P_W.
REQ-018 Addend: acc=0 -> c; acc=1, acc_clr=0 -> current out register; acc=1, acc_clr=1 -> 0.
REQ-019 Result: r = post_sub ? m-addend : m+addend, modulo 2^P_W.
REQ-020 Stage placement: STAGES=1 registers r only; 2 adds input register; 3 adds product register; 4 adds pre-adder register.
REQ-021 Every pipeline stage SHALL carry a valid bit and the mode/acc_clr bits alongside the data.
REQ-022 Latency: with ce held 1, out_valid SHALL assert exactly STAGES cycles after the in_valid sample edge.
REQ-023 Throughput: one operand set per enabled cycle; back-to-back in_valid SHALL yield back-to-back out_valid.
REQ-024 out SHALL update only when a valid set reaches the final stage with ce=1; otherwise out holds.
REQ-025 out_valid SHALL be 1 for exactly one enabled cycle per result and SHALL equal the final-stage valid bit.
REQ-026 Accumulation feedback SHALL use the out value as of the edge at which the accumulating set enters the final stage, so consecutive acc sets chain without bubbles.
REQ-027 Bubbles (in_valid=0) SHALL propagate as invalid stages and SHALL NOT disturb out or the accumulator.
REQ-028 ce=0 SHALL hold all data, valid and mode registers, including out and out_valid, indefinitely.
REQ-029 Inputs other than ce and rst_n SHALL be don't-care when in_valid=0.

Reset
REQ-030 rst_n=0 SHALL immediately clear all valid bits, out_valid=0 and out=0, regardless of clk or ce.
REQ-031 Reset mid-pipeline SHALL discard in-flight sets; the first set after deassertion accumulates from 0.
REQ-032 rst_n deassertion SHALL be synchronised externally; the block needs no cycle after release before accepting in_valid.

Verification
REQ-033 STAGES=3, mode=0000, a=3, b=5, c=10, one in_valid pulse -> out=25, out_valid high 3 cycles later for 1 cycle.
REQ-034 mode=0011, a=2, d=7 (A_W=25) -> pre=2^26-5; b=1, c=0 -> out=67108859 (checks wrap).
REQ-035 mode=1000 with acc_clr=1 first, then 4 back-to-back sets, a=1, b=1..4 -> outs 1,3,6,10 on consecutive cycles.
REQ-036 mode=0100, a=0, b=0, c=1, P_W=48 -> out=2^48-1.
REQ-037 ce=0 for 5 cycles mid-stream -> out/out_valid frozen, results unchanged and in order after ce=1; sweep STAGES 1..4.
REQ-038 rst_n low for 1 ns between edges with 2 sets in flight -> out=0, out_valid=0 at once, no stale results emerge.

Source files
------------

// File: rtl/dsp_macc_pipe.sv
// Pre-add / multiply / post-add-or-accumulate datapath with 1..4 register stages.
// Latency STAGES enabled cycles, one operand set per enabled cycle.
// No backpressure: ce=0 freezes every register, including out and out_valid.
module dsp_macc_pipe #(
    parameter int A_W    = 25,
    parameter int B_W    = 17,
    parameter int P_W    = 48,
    parameter int STAGES = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ce,
    input  logic           in_valid,
    input  logic [A_W-1:0] a,
    input  logic [A_W-1:0] d,
    input  logic [B_W-1:0] b,
    input  logic [P_W-1:0] c,
    input  logic [3:0]     mode,
    input  logic           acc_clr,
    output logic           out_valid,
    output logic [P_W-1:0] out
);

    localparam int PRE_W = A_W + 1;
    localparam int M_W   = PRE_W + B_W;

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("dsp_macc_pipe: STAGES must be in 1..4");
    end
    if (M_W > P_W || P_W > 48) begin : g_bad_pw
        $error("dsp_macc_pipe: P_W must satisfy A_W+1+B_W <= P_W <= 48");
    end

    typedef struct packed {
        logic           vld;
        logic [3:0]     mode;
        logic           clr;
        logic [A_W-1:0] a;
        logic [A_W-1:0] d;
        logic [B_W-1:0] b;
        logic [P_W-1:0] c;
    } in_t;

    typedef struct packed {
        logic             vld;
        logic [3:0]       mode;
        logic             clr;
        logic [PRE_W-1:0] pre;
        logic [B_W-1:0]   b;
        logic [P_W-1:0]   c;
    } pre_t;

    typedef struct packed {
        logic           vld;
        logic [3:0]     mode;
        logic           clr;
        logic [M_W-1:0] m;
        logic [P_W-1:0] c;
    } prod_t;

    in_t   s0_dat, s1_dat;
    pre_t  p0_dat, p1_dat;
    prod_t q0_dat, q1_dat;

    assign s0_dat = '{vld: in_valid, mode: mode, clr: acc_clr, a: a, d: d, b: b, c: c};

    // Input register (STAGES >= 2)
    if (STAGES >= 2) begin : g_in_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_dat <= '0;
            end else if (ce) begin
                s1_dat <= s0_dat;
            end
        end
    end else begin : g_in_pass
        assign s1_dat = s0_dat;
    end

    // Pre-adder wraps modulo 2^(A_W+1); a-d with d>a yields the two's-complement pattern.
    always_comb begin
        p0_dat      = '0;
        p0_dat.vld  = s1_dat.vld;
        p0_dat.mode = s1_dat.mode;
        p0_dat.clr  = s1_dat.clr;
        p0_dat.b    = s1_dat.b;
        p0_dat.c    = s1_dat.c;
        if (s1_dat.mode[0] && s1_dat.mode[1]) begin
            p0_dat.pre = {1'b0, s1_dat.a} - {1'b0, s1_dat.d};
        end else if (s1_dat.mode[0]) begin
            p0_dat.pre = {1'b0, s1_dat.a} + {1'b0, s1_dat.d};
        end else begin
            p0_dat.pre = {1'b0, s1_dat.a};
        end
    end

    // Pre-adder register (STAGES == 4)
    if (STAGES >= 4) begin : g_pre_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                p1_dat <= '0;
            end else if (ce) begin
                p1_dat <= p0_dat;
            end
        end
    end else begin : g_pre_pass
        assign p1_dat = p0_dat;
    end

    always_comb begin
        q0_dat      = '0;
        q0_dat.vld  = p1_dat.vld;
        q0_dat.mode = p1_dat.mode;
        q0_dat.clr  = p1_dat.clr;
        q0_dat.c    = p1_dat.c;
        q0_dat.m    = M_W'(p1_dat.pre) * M_W'(p1_dat.b);
    end

    // Product register (STAGES >= 3)
    if (STAGES >= 3) begin : g_prod_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q1_dat <= '0;
            end else if (ce) begin
                q1_dat <= q0_dat;
            end
        end
    end else begin : g_prod_pass
        assign q1_dat = q0_dat;
    end

    logic [P_W-1:0] m_ext;
    logic [P_W-1:0] addend;
    logic [P_W-1:0] r_dat;

    // Accumulate reads the live out register, so back-to-back acc sets chain without bubbles.
    always_comb begin
        m_ext            = '0;
        m_ext[M_W-1:0]   = q1_dat.m;
        if (!q1_dat.mode[3]) begin
            addend = q1_dat.c;
        end else if (q1_dat.clr) begin
            addend = '0;
        end else begin
            addend = out;
        end
        r_dat = q1_dat.mode[2] ? (m_ext - addend) : (m_ext + addend);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else if (ce) begin
            out_valid <= q1_dat.vld;
            if (q1_dat.vld) begin
                out <= r_dat;
            end
        end
    end

    // Pre-adder mode bits travel to the last stage but are consumed earlier.
    logic unused_mode;
    assign unused_mode = ^q1_dat.mode[1:0];

endmodule
